// File: rtl/gtp_pll_bringup.sv
// Power-up, reset and lock sequencer for the GTPE2_COMMON PLLs.
// Each PLL has its own FSM, counters and registered outputs.
module gtp_pll_bringup #(
  parameter int unsigned NUM_PLL      = 2,
  parameter int unsigned PD_CYCLES    = 64,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned LOCK_STABLE  = 8,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PLL-1:0]   enable,
  input  logic [NUM_PLL-1:0]   pll_lock,
  input  logic [NUM_PLL-1:0]   pll_refclklost,
  output logic [NUM_PLL-1:0]   pll_pd,
  output logic [NUM_PLL-1:0]   pll_reset,
  output logic [NUM_PLL-1:0]   pll_lockdet_en,
  output logic [NUM_PLL-1:0]   pll_ready,
  output logic [NUM_PLL-1:0]   pll_fail,
  output logic [4*NUM_PLL-1:0] retry_count
);

  localparam int unsigned CntMax0 = (PD_CYCLES > RST_CYCLES) ? PD_CYCLES : RST_CYCLES;
  localparam int unsigned CntMax  = (CntMax0 > LOCK_TIMEOUT) ? CntMax0 : LOCK_TIMEOUT;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned StabW   = $clog2(LOCK_STABLE + 1);

  typedef enum logic [2:0] {
    StOff, StPwrup, StReset, StWaitLock, StLocked, StFail
  } state_e;

  for (genvar g = 0; g < NUM_PLL; g++) begin : g_pll
    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [StabW-1:0]  stab_q, stab_d;
    logic [3:0]        retry_q, retry_d;
    logic              attempt_failed;
    logic              pd_q, reset_q, lden_q, ready_q, fail_q;

    always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      stab_d         = stab_q;
      retry_d        = retry_q;
      attempt_failed = 1'b0;

      unique case (state_q)
        StOff: begin
          if (enable[g]) begin
            state_d = StPwrup;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        StPwrup: begin
          if (cnt_q == CntW'(PD_CYCLES - 1)) begin
            state_d = StReset;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StReset: begin
          if (cnt_q == CntW'(RST_CYCLES - 1)) begin
            state_d = StWaitLock;
            cnt_d   = '0;
            stab_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StWaitLock: begin
          stab_d = pll_lock[g] ? stab_q + 1'b1 : '0;
          cnt_d  = cnt_q + 1'b1;
          // Lost reference aborts at once; a completed lock beats a same-cycle timeout.
          if (pll_refclklost[g]) begin
            attempt_failed = 1'b1;
          end else if (pll_lock[g] && (stab_q == StabW'(LOCK_STABLE - 1))) begin
            state_d = StLocked;
          end else if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
            attempt_failed = 1'b1;
          end
        end
        StLocked: begin
          if (!pll_lock[g] || pll_refclklost[g]) attempt_failed = 1'b1;
        end
        StFail: ;
        default: state_d = StOff;
      endcase

      if (attempt_failed) begin
        if (retry_q < 4'(MAX_RETRIES)) begin
          state_d = StReset;
          cnt_d   = '0;
          retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
        end else begin
          state_d = StFail;
        end
      end

      if (!enable[g]) begin
        state_d = StOff;
        cnt_d   = '0;
        stab_d  = '0;
        retry_d = '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= StOff;
        cnt_q   <= '0;
        stab_q  <= '0;
        retry_q <= '0;
        pd_q    <= 1'b1;
        reset_q <= 1'b0;
        lden_q  <= 1'b0;
        ready_q <= 1'b0;
        fail_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        stab_q  <= stab_d;
        retry_q <= retry_d;
        pd_q    <= (state_d == StOff) || (state_d == StFail);
        reset_q <= (state_d == StReset);
        lden_q  <= state_d inside {StPwrup, StReset, StWaitLock, StLocked};
        // Ready trails LOCKED entry by one cycle but drops with the exit edge.
        ready_q <= (state_q == StLocked) && (state_d == StLocked);
        fail_q  <= (state_d == StFail);
      end
    end

    assign pll_pd[g]            = pd_q;
    assign pll_reset[g]         = reset_q;
    assign pll_lockdet_en[g]    = lden_q;
    assign pll_ready[g]         = ready_q;
    assign pll_fail[g]          = fail_q;
    assign retry_count[4*g +: 4] = retry_q;
  end

endmodule

// File: tb/tb_gtp_pll_bringup.sv
// Randomised bench for gtp_pll_bringup: a phase/countdown reference model predicts
// every cycle's outputs into a queue that an independent monitor drains.
module tb_gtp_pll_bringup;
  localparam int PD = 64, RC = 16, TO = 4096, ST = 8, MR = 3;
  localparam int MOff = 0, MPwrup = 1, MReset = 2, MWait = 3, MLocked = 4, MFail = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] enable, pll_lock, pll_refclklost;
  logic [1:0] pll_pd, pll_reset, pll_lockdet_en, pll_ready, pll_fail;
  logic [7:0] retry_count;

  always #5 clk = ~clk;

  gtp_pll_bringup #(
    .NUM_PLL(2), .PD_CYCLES(PD), .RST_CYCLES(RC), .LOCK_TIMEOUT(TO),
    .LOCK_STABLE(ST), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pll_lock(pll_lock),
    .pll_refclklost(pll_refclklost), .pll_pd(pll_pd), .pll_reset(pll_reset),
    .pll_lockdet_en(pll_lockdet_en), .pll_ready(pll_ready), .pll_fail(pll_fail),
    .retry_count(retry_count)
  );

  typedef struct packed {
    logic [1:0] pd, rs, le, rdy, fl;
    logic [7:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;

  // Reference model: phase plus cycles-left countdown per PLL.
  int m_ph[2], m_left[2], m_streak[2], m_tries[2];
  bit m_rdy[2];
  // Stimulus knobs.
  int mode[2], lostr[2], since[2], delay[2];
  int glitch_rate = 0, glitch_cyc = -1, cyc = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, req);
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int i = 0; i < 2; i++) begin
      e.pd[i]         = (m_ph[i] == MOff) || (m_ph[i] == MFail);
      e.rs[i]         = (m_ph[i] == MReset);
      e.le[i]         = (m_ph[i] >= MPwrup) && (m_ph[i] <= MLocked);
      e.rdy[i]        = m_rdy[i];
      e.fl[i]         = (m_ph[i] == MFail);
      e.rc[4*i +: 4]  = 4'(m_tries[i]);
    end
    return e;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = MOff; m_left[i] = 0; m_streak[i] = 0; m_tries[i] = 0; m_rdy[i] = 0;
      since[i] = 0;
    end
  endfunction

  function automatic void attempt_failed(input int i);
    if (m_tries[i] < MR) begin
      m_tries[i] = (m_tries[i] < 15) ? m_tries[i] + 1 : 15;
      m_ph[i]    = MReset;
      m_left[i]  = RC;
    end else begin
      m_ph[i] = MFail;
    end
  endfunction

  function automatic void model_step(input int i, input bit en, input bit lock, input bit lost);
    int prev;
    prev = m_ph[i];
    if (!en) begin
      m_ph[i] = MOff; m_tries[i] = 0; m_rdy[i] = 0;
      return;
    end
    case (m_ph[i])
      MOff: begin m_ph[i] = MPwrup; m_left[i] = PD; m_tries[i] = 0; end
      MPwrup: begin
        m_left[i]--;
        if (m_left[i] == 0) begin m_ph[i] = MReset; m_left[i] = RC; end
      end
      MReset: begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_ph[i] = MWait; m_left[i] = TO; m_streak[i] = 0;
          since[i] = -1; delay[i] = $urandom_range(0, 30);
        end
      end
      MWait: begin
        m_streak[i] = lock ? m_streak[i] + 1 : 0;
        m_left[i]--;
        if (lost) attempt_failed(i);
        else if (m_streak[i] >= ST) m_ph[i] = MLocked;
        else if (m_left[i] == 0) attempt_failed(i);
      end
      MLocked: if (!lock || lost) attempt_failed(i);
      default: ;
    endcase
    m_rdy[i] = (prev == MLocked) && (m_ph[i] == MLocked);
    if (m_ph[i] == MWait || m_ph[i] == MLocked) since[i]++;
  endfunction

  function automatic bit gen_lock(input int i);
    bit l;
    case (mode[i])
      1: begin
        l = (m_ph[i] == MWait || m_ph[i] == MLocked) && (since[i] >= delay[i]);
        if (glitch_rate != 0 && m_ph[i] == MLocked && $urandom_range(0, glitch_rate - 1) == 0)
          l = 1'b0;
      end
      2: l = (cyc % 3) != 2;
      3: l = $urandom_range(0, 7) != 0;
      default: l = 1'b0;
    endcase
    if (i == 0 && cyc == glitch_cyc) l = 1'b0;
    return l;
  endfunction

  task automatic cycle(input bit r, input bit [1:0] en);
    bit [1:0] lk, ls;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      lk[i] = gen_lock(i);
      ls[i] = (lostr[i] != 0) && ($urandom_range(0, lostr[i] - 1) == 0);
    end
    rst = r; enable = en; pll_lock = lk; pll_refclklost = ls;
    if (r) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i, en[i], lk[i], ls[i]);
    exp_q.push_back(model_out());
    cyc++;
  endtask

  task automatic run(input int n, input bit [1:0] en);
    for (int k = 0; k < n; k++) cycle(1'b0, en);
  endtask

  function automatic logic [31:0] outs();
    return {14'd0, pll_pd, pll_reset, pll_lockdet_en, pll_ready, pll_fail, retry_count};
  endfunction

  // Monitor: the DUT presents a fresh output set after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle_outputs", outs(), {14'd0, e});
      end
    end
  end

  initial begin
    exp_t rv;
    rv = '0;
    rv.pd = 2'b11;
    mode = '{0, 0}; lostr = '{0, 0};
    rst = 1'b1; enable = 2'b00; pll_lock = 2'b00; pll_refclklost = 2'b00;
    model_reset();
    #1;
    check("reset_state", outs(), {14'd0, rv});
    cycle(1'b1, 2'b01);
    cycle(1'b1, 2'b01);

    // Clean bring-up of PLL0, then one forced lock glitch and relock.
    mode = '{1, 0};
    glitch_cyc = cyc + 1500;
    run(2000, 2'b01);
    check("p1_ready", 32'(pll_ready), 32'h1);
    check("p1_retry", 32'(retry_count), 32'h01);

    // PLL1 never locks and exhausts retries while PLL0 stays up.
    run(17500, 2'b11);
    check("p2_ready", 32'(pll_ready), 32'h1);
    check("p2_fail", 32'(pll_fail), 32'h2);
    check("p2_retry1", 32'(retry_count[7:4]), 32'h3);
    run(20, 2'b01);
    check("p2_fail_clear", 32'(pll_fail), 32'h0);
    check("p2_pll0_kept", 32'({pll_ready, retry_count}), 32'h101);

    // Chattering lock on PLL0 never qualifies; noisy lock on PLL1.
    mode = '{2, 3};
    run(17000, 2'b11);
    check("p3_never_ready0", 32'(pll_ready[0]), 32'h0);
    check("p3_fail0", 32'(pll_fail[0]), 32'h1);

    // Async reset while PLL0 is locked, then full repeat.
    mode = '{1, 0};
    run(5, 2'b00);
    run(300, 2'b01);
    check("p4_locked", 32'(pll_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst", outs(), {14'd0, rv});
    model_reset();
    exp_q.push_back(model_out());
    cyc++;
    cycle(1'b1, 2'b01);
    cycle(1'b1, 2'b01);
    run(300, 2'b01);
    check("p4_relocked", 32'(pll_ready), 32'h1);

    // Random segments: enables, modes, glitches and refclk loss.
    glitch_rate = 400;
    for (int s = 0; s < 20; s++) begin
      mode[0]  = $urandom_range(0, 3);
      mode[1]  = $urandom_range(0, 3);
      lostr[0] = ($urandom_range(0, 1) != 0) ? 300 : 0;
      lostr[1] = ($urandom_range(0, 1) != 0) ? 300 : 0;
      run(600, 2'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gtp_pll_bringup.md
GTP_PLL_BRINGUP -- requirements
Module: gtp_pll_bringup

Interface
REQ-001 SHALL have parameter NUM_PLL, default 2, meaning number of independent GTP common PLLs sequenced (legal 1..2).
REQ-002 SHALL have parameter PD_CYCLES, default 64, meaning power-up settle cycles after PLLxPD deasserts (legal ≥1).
REQ-003 SHALL have parameter RST_CYCLES, default 16, meaning PLLxRESET pulse width in cycles (legal ≥1).
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 4096, meaning cycles allowed for lock per attempt (legal ≥2).
REQ-005 SHALL have parameter LOCK_STABLE, default 8, meaning consecutive lock-high cycles required to declare lock (legal ≥1).
REQ-006 SHALL have parameter MAX_RETRIES, default 3, meaning reset retries per enable before FAIL (legal 0..15).
REQ-007 SHALL have port clk, input, 1, meaning the single clock.
REQ-008 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-009 SHALL have port enable, input, NUM_PLL, meaning per-PLL bring-up request.
REQ-010 SHALL have port pll_lock, input, NUM_PLL, meaning PLLxLOCK from GTPE2_COMMON, already synchronised to clk.
REQ-011 SHALL have port pll_refclklost, input, NUM_PLL, meaning PLLxREFCLKLOST, already synchronised.
REQ-012 SHALL have port pll_pd, output, NUM_PLL, meaning PLLxPD drive.
REQ-013 SHALL have port pll_reset, output, NUM_PLL, meaning PLLxRESET drive.
REQ-014 SHALL have port pll_lockdet_en, output, NUM_PLL, meaning PLLxLOCKEN drive.
REQ-015 SHALL have port pll_ready, output, NUM_PLL, meaning PLL locked and stable.
REQ-016 SHALL have port pll_fail, output, NUM_PLL, meaning retries exhausted.
REQ-017 SHALL have port retry_count, output, 4*NUM_PLL, meaning per-PLL retries used since last enable rise, PLL i at bits [4i+3:4i].

Function
REQ-018 SHALL run one independent FSM per PLL: OFF, PWRUP, RESET, WAIT_LOCK, LOCKED, FAIL.
REQ-019 OFF: pd=1, reset=0, lockdet_en=0, ready=0; enable=1 -> PWRUP, retry counter cleared to 0.
REQ-020 PWRUP: pd=0, lockdet_en=1; after exactly PD_CYCLES cycles in state -> RESET.
REQ-021 RESET: reset=1 for exactly RST_CYCLES cycles, then -> WAIT_LOCK with timeout and stability counters cleared.
REQ-022 WAIT_LOCK: stability counter increments while pll_lock=1, clears to 0 on any pll_lock=0 cycle; reaching LOCK_STABLE -> LOCKED.
REQ-023 WAIT_LOCK: timeout counter reaching LOCK_TIMEOUT without lock -> RESET if retries < MAX_RETRIES (retries incremented), else -> FAIL.
REQ-024 LOCKED: ready=1 registered, asserted the cycle after entry; pll_lock=0 or pll_refclklost=1 -> ready=0 next cycle and -> RESET if retries < MAX_RETRIES (retries incremented), else -> FAIL.
REQ-025 pll_refclklost=1 in WAIT_LOCK SHALL count as a failed attempt, same rule as REQ-023, without waiting for timeout.
REQ-026 FAIL: pd=1, reset=0, lockdet_en=0, fail=1; held until enable=0.
REQ-027 enable=0 in any state SHALL force OFF on the next edge; counters cleared; retry_count cleared; fail cleared.
REQ-028 Simultaneous timeout and stable-lock completion in WAIT_LOCK: lock wins (-> LOCKED).
REQ-029 retry_count SHALL saturate at 15 and never wrap.
REQ-030 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-031 PLLs SHALL not interact; events on PLL i never change PLL j outputs.

Reset
REQ-032 rst=1 SHALL asynchronously force all FSMs to OFF: pll_pd all 1, pll_reset/pll_lockdet_en/pll_ready/pll_fail all 0, retry_count 0, all counters 0.
REQ-033 rst asserted mid-sequence SHALL abort immediately; after rst release with enable held 1, sequencing restarts at PWRUP on the first clock edge.

Verification
REQ-034 Default params, enable[0]=1, pll_lock[0] rises 10 cycles after reset pulse ends -> pll_reset[0] high exactly 16 cycles after 64 PWRUP cycles; pll_ready[0]=1 LOCK_STABLE+1 cycles after lock rise; retry_count 0.
REQ-035 enable[0]=1, pll_lock[0] never rises -> 4 reset pulses (initial + 3 retries), then pll_fail[0]=1, pll_pd[0]=1, retry_count[3:0]=3.
REQ-036 LOCKED, pll_lock[0] glitches low 1 cycle -> pll_ready[0]=0 next cycle, new 16-cycle reset pulse, retry_count[3:0]=1, relock -> ready again.
REQ-037 pll_lock toggling 1,1,0,1... with period shorter than LOCK_STABLE -> never ready; timeout retries occur as in REQ-035.
REQ-038 Both PLLs enabled, PLL1 lock never rises, PLL0 locks -> pll_ready=2'b01, pll_fail=2'b10; dropping enable[1] clears pll_fail[1] without disturbing PLL0.
REQ-039 rst pulsed while PLL0 LOCKED -> all outputs at REQ-032 values within the same cycle; full sequence repeats after release.
